// File: rtl/ggt_pkg.sv
// ggt_pkg: definitions shared by the GCD result display stage.
//   state_t     - display FSM state encoding (2 bits)
//   SEG_*       - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   NUM_DIGITS  - number of multiplexed display digits
//   BCD_WIDTH   - width of the three-digit BCD display register
package ggt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_WIDTH  = 12;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
//   bcd   in  4  BCD digit 0..9 (codes 10..15 render blank)
//   blank in  1  force all segments off
//   seg   out 7  segments {g,f,e,d,c,b,a}, active-low
module seg7_dec
    import ggt_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ggt_display.sv
// ggt_display: captures each non-zero GCD result, converts it to BCD with a
// sequential double-dabble converter and drives a 4-digit multiplexed
// common-anode 7-segment display with leading-zero blanking.
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous reset, active-low
//   ggt   in  8  GCD result, non-zero for one cycle when a result is ready
//   clr   in  1  synchronous clear of the held value, active-high
//   seg   out 7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an    out 4  digit enables, active-low one-hot, an[0] = ones, registered
//   busy  out 1  conversion in progress
//   valid out 1  a converted value is being displayed
module ggt_display
    import ggt_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ggt,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic       valid
);

    localparam int              PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_TC = PW'(SCAN_DIV - 1);
    localparam int              IW       = $clog2(NUM_DIGITS);
    localparam int              SRW      = BCD_WIDTH + 8;

    // One double-dabble iteration: nibbles >= 5 get +3, then shift left.
    function automatic logic [SRW-1:0] dabble(input logic [SRW-1:0] v);
        logic [SRW-1:0] t;
        t = v;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[SRW-2:0], 1'b0};
    endfunction

    state_t                 state, state_n;
    logic [2:0]             iter;
    logic [SRW-1:0]         sr, sr_nxt;
    logic [BCD_WIDTH-1:0]   disp;
    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic [3:0]             dig;
    logic                   dig_blank;
    logic [6:0]             seg_d;
    logic                   capture;
    logic                   last_iter;

    // clr has priority over a result arriving in the same cycle.
    assign capture   = (state != CONV) && (ggt != 8'd0) && !clr;
    assign last_iter = (state == CONV) && (iter == 3'd7) && !clr;
    assign sr_nxt    = dabble(sr);

    assign busy  = (state == CONV);
    assign valid = (state == SHOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, SHOW: begin
                if (clr)          state_n = IDLE;
                else if (capture) state_n = CONV;
            end
            CONV: begin
                if (clr)            state_n = IDLE;
                else if (last_iter) state_n = SHOW;
            end
            default: state_n = IDLE;
        endcase
    end

    // Conversion shift register: pure data, always loaded before use.
    always_ff @(posedge clk) begin
        if (capture)             sr <= {{BCD_WIDTH{1'b0}}, ggt};
        else if (state == CONV)  sr <= sr_nxt;
    end

    // Iteration count and held display value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter <= 3'd0;
            disp <= '0;
        end else begin
            if (capture)             iter <= 3'd0;
            else if (state == CONV)  iter <= iter + 3'd1;
            if (last_iter)           disp <= sr_nxt[SRW-1:8];
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_TC) begin
            presc <= '0;
            idx   <= idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit selection with leading-zero blanking; everything blank unless
    // a finished value is on display.
    always_comb begin
        dig       = 4'd0;
        dig_blank = 1'b1;
        if (valid) begin
            case (idx)
                2'd0: begin
                    dig       = disp[3:0];
                    dig_blank = 1'b0;
                end
                2'd1: begin
                    dig       = disp[7:4];
                    dig_blank = (disp[11:4] == 8'd0);
                end
                2'd2: begin
                    dig       = disp[11:8];
                    dig_blank = (disp[11:8] == 4'd0);
                end
                default: begin
                    dig       = 4'd0;
                    dig_blank = 1'b1;
                end
            endcase
        end
    end

    seg7_dec u_dec (
        .bcd   (dig),
        .blank (dig_blank),
        .seg   (seg_d)
    );

    // Output registers: seg/an follow idx and the display value one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1110;
        end else begin
            seg <= seg_d;
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_ggt_display.sv
module tb_ggt_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ggt = 8'd0;
    logic       clr = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       valid;

    int checks = 0;
    int errors = 0;

    ggt_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .ggt   (ggt),
        .clr   (clr),
        .seg   (seg),
        .an    (an),
        .busy  (busy),
        .valid (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  v;
        logic [27:0] e;   // {slot3, slot2, slot1, slot0} segment codes
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    function automatic logic [6:0] segc(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference display contents for value v: decimal digits with leading zeros blanked.
    function automatic logic [27:0] model(input int v, input bit shown);
        int h, t, o;
        logic [6:0] s0, s1, s2;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        s0 = shown ? segc(o) : 7'h7F;
        s1 = (shown && (h != 0 || t != 0)) ? segc(t) : 7'h7F;
        s2 = (shown && h != 0) ? segc(h) : 7'h7F;
        return {7'h7F, s2, s1, s0};
    endfunction

    task automatic wait_an(input logic [3:0] tgt, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        while (!ok && n < 4 * SCAN_DIV + 4) begin
            if (an == tgt) ok = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic check_slots(input string nm, input logic [27:0] e);
        bit ok;
        logic [3:0] tgt;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            tgt = ~(4'b0001 << s);
            wait_an(tgt, ok);
            if (!ok) chk({nm, "_an_timeout"}, {28'd0, an}, {28'd0, tgt});
            else     chk($sformatf("%s_slot%0d", nm, s), {25'd0, seg}, {25'd0, e[s*7 +: 7]});
        end
    endtask

    // Pulse ggt for one cycle, measure how many cycles busy stays high.
    task automatic capture(input logic [7:0] v, output int n);
        @(negedge clk);
        ggt = v;
        @(negedge clk);
        ggt = 8'd0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] cur;
        logic [3:0] rot [4];
        logic [7:0] v;

        tbl[0] = '{8'd6,   {7'h7F, 7'h7F, 7'h7F, 7'h02}};
        tbl[1] = '{8'd255, {7'h7F, 7'h24, 7'h12, 7'h12}};
        tbl[2] = '{8'd100, {7'h7F, 7'h79, 7'h40, 7'h40}};
        tbl[3] = '{8'd1,   {7'h7F, 7'h7F, 7'h7F, 7'h79}};
        tbl[4] = '{8'd12,  {7'h7F, 7'h7F, 7'h79, 7'h24}};
        tbl[5] = '{8'd205, {7'h7F, 7'h24, 7'h40, 7'h12}};
        tbl[6] = '{8'd90,  {7'h7F, 7'h7F, 7'h10, 7'h40}};
        tbl[7] = '{8'd10,  {7'h7F, 7'h7F, 7'h79, 7'h40}};
        rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

        // Reset held
        repeat (5) @(negedge clk);
        chk("rst_seg",   {25'd0, seg}, 32'h7F);
        chk("rst_an",    {28'd0, an},  32'h0E);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b1;
        n = 0;
        while (an == 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rot_first_delay", n, 5);
        chk("rot_first_an", {28'd0, an}, {28'd0, rot[0]});
        for (int k = 1; k < 4; k++) begin
            cur = an;
            n = 0;
            while (an == cur && n < 20) begin
                chk("rot_seg_blank", {25'd0, seg}, 32'h7F);
                @(negedge clk);
                n++;
            end
            chk("rot_dwell", n, SCAN_DIV);
            chk("rot_an", {28'd0, an}, {28'd0, rot[k]});
        end

        // Table-driven values
        for (int i = 0; i < 8; i++) begin
            capture(tbl[i].v, n);
            chk($sformatf("tbl%0d_busy_cycles", i), n, 8);
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, 32'd1);
            check_slots($sformatf("tbl%0d", i), tbl[i].e);
        end

        // Random values against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom_range(1, 255));
            capture(v, n);
            chk($sformatf("rnd%0d_busy_cycles", i), n, 8);
            chk($sformatf("rnd%0d_valid", i), {31'd0, valid}, 32'd1);
            check_slots($sformatf("rnd%0d_v%0d", i, v), model(int'(v), 1'b1));
        end

        // Second result during CONV is ignored
        @(negedge clk);
        ggt = 8'd12;
        @(negedge clk);
        ggt = 8'd0;
        @(negedge clk);
        @(negedge clk);
        ggt = 8'd200;
        @(negedge clk);
        ggt = 8'd0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_busy_rest", n, 5);
        chk("ignore_valid", {31'd0, valid}, 32'd1);
        check_slots("ignore", model(12, 1'b1));

        // clr in SHOW blanks the display
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_show_valid", {31'd0, valid}, 32'd0);
        chk("clr_show_busy",  {31'd0, busy},  32'd0);
        check_slots("clr_show", model(0, 1'b0));

        // clr together with ggt: clr wins
        ggt = 8'd7;
        clr = 1'b1;
        @(negedge clk);
        ggt = 8'd0;
        clr = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy || valid) n++;
            @(negedge clk);
        end
        chk("clr_ggt_no_busy", n, 0);

        // clr at CONV cycle 4 aborts
        capture(8'd42, n);
        check_slots("pre_abort", model(42, 1'b1));
        @(negedge clk);
        ggt = 8'd7;
        @(negedge clk);
        ggt = 8'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy || valid) n++;
            @(negedge clk);
        end
        chk("abort_stays_idle", n, 0);
        check_slots("abort", model(0, 1'b0));

        // Asynchronous reset mid-CONV
        @(negedge clk);
        ggt = 8'd99;
        @(negedge clk);
        ggt = 8'd0;
        repeat (4) @(negedge clk);
        chk("rst_conv_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_seg",   {25'd0, seg}, 32'h7F);
        chk("async_an",    {28'd0, an},  32'h0E);
        chk("async_busy",  {31'd0, busy},  32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || valid) n++;
            @(negedge clk);
        end
        chk("post_rst_idle", n, 0);
        check_slots("post_rst", model(0, 1'b0));
        capture(8'd99, n);
        chk("post_rst_busy_cycles", n, 8);
        check_slots("post_rst_99", model(99, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ggt_display.md
# ggt_display

Result display stage directly downstream of the GCD unit. Captures each non-zero 8-bit GCD result, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter, and drives a 4-digit multiplexed common-anode 7-segment display with leading-zero blanking. The held value stays on the display until a new result arrives or it is cleared.

## Interface
- SCAN_DIV, default 50000: clock cycles each digit stays enabled; minimum 2.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- ggt  in  8  GCD result; non-zero only in the cycle the GCD unit is READY, else 0.
- clr  in  1  synchronous clear of the held value, active-high.
- seg  out 7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an   out 4  digit enables, active-low one-hot, an[0] = ones, registered.
- busy out 1  conversion in progress.
- valid out 1  a converted value is being displayed.

## Operation
- FSM states: IDLE, CONV, SHOW.
- IDLE/SHOW: sampled ggt != 0 → load shift register {12'b0, ggt}, iteration count 0, go to CONV.
- CONV: one iteration per cycle: every BCD nibble ≥ 5 gets +3, then the 20-bit register shifts left 1. After the 8th iteration, write bits [19:8] to the display register (hundreds, tens, ones), go to SHOW.
- CONV ignores ggt (the GCD unit cannot produce two results within 8 cycles).
- clr: IDLE/SHOW → IDLE; CONV → IDLE (abort, display register not written). clr and a non-zero ggt in the same cycle: clr wins, ggt dropped.
- busy = (state == CONV); valid = (state == SHOW).
- Digit mapping: an[3] always blank; an[2] hundreds, blank if 0; an[1] tens, blank if hundreds and tens both 0; an[0] ones, always shown.
- valid=0 (including during CONV after a previous value): all digits blank (seg = 7'h7F); scanning continues.
- Segment codes (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F (hex).

## Timing
- Reset values: seg=7'h7F, an=4'b1110, busy=0, valid=0, state IDLE, prescaler 0, digit index 0, display register 0.
- Capture at edge T (ggt non-zero sampled) → busy=1 after T through T+8; display register written and valid=1 at edge T+8; busy=0 after T+8.
- Prescaler counts 0..SCAN_DIV-1; at terminal count the digit index advances 0→1→2→3→0 (wrap).
- seg/an are registered from digit index and display register: they reflect a change one cycle after it.
- rst asserted mid-CONV: immediate return to reset values; no partial value displayed after release.
- Minimum ggt = 1 → displays "1"; maximum 255 → "255". Width: 8-bit input fully representable in 3 BCD digits; no overflow case.

## Structure
- Shared package ggt_pkg: FSM state encoding (2-bit), segment constants SEG_0..SEG_9 and SEG_BLANK, NUM_DIGITS=4, BCD_WIDTH=12.
- One sub-module: seg7_dec, combinational 4-bit BCD + blank flag → 7-bit active-low segments.
- Converter, prescaler, scan counter and output registers stay in ggt_display.

## Test plan
(SCAN_DIV=4 for all scenarios.)
- Reset: hold rst=0, toggle clk → seg=7'h7F, an=4'b1110, busy=0, valid=0; release → an rotates 1110→1101→1011→0111 every 4 cycles, seg stays 7F.
- ggt=8'd6 for one cycle → busy high exactly 8 cycles, then valid=1; an[0] slot seg=7'h02, an[1]/an[2]/an[3] slots seg=7'h7F.
- ggt=8'd255 → digits 2,5,5: an[2] seg=24, an[1] seg=12, an[0] seg=12; ggt=8'd100 → 79, 40, 40 (inner zero not blanked).
- ggt=8'd12 then ggt=8'd200 3 cycles later (inside CONV) → second value ignored, display shows 12 (79, 24); clr in SHOW → valid=0, all blank.
- clr asserted in the same cycle as ggt=8'd7 → stays IDLE, busy never rises; clr at CONV cycle 4 → IDLE, valid=0, previous value not shown.
- rst pulled low at CONV cycle 5 after ggt=8'd99 → outputs at reset values asynchronously; after release, valid stays 0 until the next non-zero ggt.
